// File: rtl/mem_byte_seq.sv
// Byte-serial load/store sequencer: splits byte/half/word requests into single-byte RAM cycles, little-endian.
// Latency: accept at T0, RAM cycles T0+1..T0+N, resp_valid from T0+N+1 (precheck fault: from T0+1).
// Backpressure: resp held stable until resp_ready; req_ready only in IDLE. Macro MEM_BYTE_SEQ_MISALIGN_EN drops alignment checks.
module mem_byte_seq #(
  parameter int unsigned ram_width     = 12,
  parameter bit          ZERO_ON_FAULT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_len,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write,
  input  logic [31:0] mem_read,
  input  logic        mem_exception
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  // Highest legal byte address, kept in 33 bits so it compares against the unwrapped end address
  localparam logic [32:0] ADDR_MAX = (33'd1 << ram_width) - 33'd1;

  state_t      state_q, state_d;
  logic        we_q, signed_q, fault_q;
  logic [1:0]  len_q, idx_q, last_idx;
  logic [31:0] addr_q, wdata_q, acc_q;
  logic [7:0]  wbyte;
  logic [31:0] load_val;

  logic [2:0]  req_n;
  logic [32:0] req_end;
  logic        misalign;
  logic        pre_fault;

  // Only the low RAM data byte carries information
  logic        mem_read_unused;
  assign mem_read_unused = ^mem_read[31:8];

  // Precheck on the incoming request: illegal length, alignment, range (end address in 33 bits)
  always_comb begin
    req_n = 3'd1;
    case (req_len)
      2'b01:   req_n = 3'd2;
      2'b10:   req_n = 3'd4;
      default: req_n = 3'd1;
    endcase
    req_end = {1'b0, req_addr} + {30'b0, req_n} - 33'd1;
`ifdef MEM_BYTE_SEQ_MISALIGN_EN
    misalign = 1'b0;
`else
    misalign = ((req_len == 2'b01) && req_addr[0]) ||
               ((req_len == 2'b10) && (req_addr[1:0] != 2'b00));
`endif
    pre_fault = (req_len == 2'b11) || misalign || (req_end > ADDR_MAX);
  end

  // Index of the final byte of the latched transfer and the store byte for this cycle
  always_comb begin
    last_idx = 2'd0;
    case (len_q)
      2'b01:   last_idx = 2'd1;
      2'b10:   last_idx = 2'd3;
      default: last_idx = 2'd0;
    endcase
    wbyte = wdata_q[7:0];
    case (idx_q)
      2'd1:    wbyte = wdata_q[15:8];
      2'd2:    wbyte = wdata_q[23:16];
      2'd3:    wbyte = wdata_q[31:24];
      default: wbyte = wdata_q[7:0];
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and RAM/handshake outputs; write strobe is masked while reset is asserted
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_rw     = 1'b0;
    mem_addr   = 32'd0;
    mem_write  = 32'd0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = pre_fault ? RESP : XFER;
      end
      XFER: begin
        mem_addr  = addr_q + {30'b0, idx_q};
        mem_write = {24'b0, wbyte};
        mem_rw    = rst_n & we_q & ~mem_exception;
        if (mem_exception || (idx_q == last_idx)) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, byte index and load-data accumulator
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      len_q    <= 2'b00;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      acc_q    <= 32'd0;
      idx_q    <= 2'd0;
      fault_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            signed_q <= req_signed;
            len_q    <= req_len;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            acc_q    <= 32'd0;
            idx_q    <= 2'd0;
            fault_q  <= pre_fault;
          end
        end
        XFER: begin
          if (mem_exception) begin
            fault_q <= 1'b1;
          end else begin
            if (!we_q) acc_q[{idx_q, 3'b000} +: 8] <= mem_read[7:0];
            idx_q <= idx_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Response data: extend the accumulated load, zero for stores and (optionally) for faults
  always_comb begin
    case (len_q)
      2'b00:   load_val = {{24{signed_q & acc_q[7]}}, acc_q[7:0]};
      2'b01:   load_val = {{16{signed_q & acc_q[15]}}, acc_q[15:0]};
      default: load_val = acc_q;
    endcase
    resp_rdata = 32'd0;
    resp_fault = 1'b0;
    if (state_q == RESP) begin
      resp_fault = fault_q;
      if (!we_q && !(fault_q && ZERO_ON_FAULT)) resp_rdata = load_val;
    end
  end

endmodule

// File: tb/tb_mem_byte_seq.sv
// Scoreboard bench for mem_byte_seq: byte RAM model, expected writes and responses queued at stimulus time.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// resp_ready held high except in the backpressure scenario.
module tb_mem_byte_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_len;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_rdata;
  logic        mem_rw, mem_exception;
  logic [31:0] mem_addr, mem_write, mem_read;

  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic [31:0] rdata; logic fault; } rsp_t;
  wr_t  wr_q[$];
  rsp_t rsp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  bit [7:0]    ram [4096];
  logic        pre_en = 1'b0;
  logic [11:0] pre_a  = 12'd0;
  logic [7:0]  pre_d  = 8'd0;
  logic        exc_en = 1'b0;
  logic [31:0] exc_addr = 32'd0;

  always #5 clk = ~clk;

  mem_byte_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_len(req_len),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_read(mem_read), .mem_exception(mem_exception)
  );

  // RAM model: combinational read, write on rising edge, out-of-range flag plus one injectable faulting address
  assign mem_read      = {24'b0, ram[mem_addr[11:0]]};
  assign mem_exception = (mem_addr >= 32'd4096) || (exc_en && (mem_addr == exc_addr));

  always @(posedge clk) begin
    if (pre_en) ram[pre_a] <= pre_d;
    else if (mem_rw && (mem_addr < 32'd4096)) ram[mem_addr[11:0]] <= mem_write[7:0];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: every RAM write and every response handshake is matched against the queues
  always @(negedge clk) begin
    if (mem_rw) begin
      if (wr_q.size() == 0) chk("wr_unexpected", 32'(mem_rw), 32'd0);
      else begin
        wr_t w;
        w = wr_q.pop_front();
        chk("wr_addr", mem_addr, w.a);
        chk("wr_data", mem_write, {24'b0, w.d});
      end
    end
    if (resp_valid && resp_ready) begin
      if (rsp_q.size() == 0) chk("rsp_unexpected", 32'(resp_valid), 32'd0);
      else begin
        rsp_t r;
        r = rsp_q.pop_front();
        chk("rsp_rdata", resp_rdata, r.rdata);
        chk("rsp_fault", 32'(resp_fault), 32'(r.fault));
      end
    end
  end

  task automatic push_wr(input logic [31:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a; w.d = d;
    wr_q.push_back(w);
  endtask

  task automatic push_rsp(input logic [31:0] rdata, input logic fault);
    rsp_t r;
    r.rdata = rdata; r.fault = fault;
    rsp_q.push_back(r);
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    pre_en = 1'b1; pre_a = a; pre_d = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic drive(input logic we, input logic [1:0] len, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_we = we; req_len = len; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
  endtask

  // One request with resp_ready high; checks the accept-to-resp_valid distance in cycles
  task automatic run_req(input string tag, input logic we, input logic [1:0] len, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat);
    int k;
    @(posedge clk); #1;
    drive(we, len, sgn, addr, wdata);
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!resp_valid && k < 20);
    chk({tag, "_lat"}, 32'(k), 32'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_len = 2'b00; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_fault", 32'(resp_fault), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_rw", 32'(mem_rw), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_write", mem_write, 32'd0);

    // Word store, little-endian byte order
    push_wr(32'h100, 8'hEF); push_wr(32'h101, 8'hBE); push_wr(32'h102, 8'hAD); push_wr(32'h103, 8'hDE);
    push_rsp(32'd0, 1'b0);
    run_req("st_word", 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 5);

    // Half loads, signed and unsigned
    poke(12'h200, 8'h34); poke(12'h201, 8'h89);
    push_rsp(32'hFFFF8934, 1'b0);
    run_req("ld_half_s", 1'b0, 2'b01, 1'b1, 32'h200, 32'd0, 3);
    push_rsp(32'h00008934, 1'b0);
    run_req("ld_half_u", 1'b0, 2'b01, 1'b0, 32'h200, 32'd0, 3);

    // Read back stored word, signed/unsigned bytes
    push_rsp(32'hDEADBEEF, 1'b0);
    run_req("ld_word", 1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 5);
    push_rsp(32'hFFFFFFDE, 1'b0);
    run_req("ld_byte_s", 1'b0, 2'b00, 1'b1, 32'h103, 32'd0, 2);
    push_rsp(32'h000000DE, 1'b0);
    run_req("ld_byte_u", 1'b0, 2'b00, 1'b0, 32'h103, 32'd0, 2);

    // Range boundary: last legal word, then out-of-range accesses
    push_rsp(32'd0, 1'b1);
    run_req("rng_w_ffe", 1'b1, 2'b10, 1'b0, 32'hFFE, 32'hCAFEF00D, 1);
    push_rsp(32'd0, 1'b1);
    run_req("rng_w_1000", 1'b1, 2'b10, 1'b0, 32'h1000, 32'hCAFEF00D, 1);
    push_wr(32'hFFC, 8'h44); push_wr(32'hFFD, 8'h33); push_wr(32'hFFE, 8'h22); push_wr(32'hFFF, 8'h11);
    push_rsp(32'd0, 1'b0);
    run_req("st_word_top", 1'b1, 2'b10, 1'b0, 32'hFFC, 32'h11223344, 5);
    push_rsp(32'h00000011, 1'b0);
    run_req("ld_byte_top", 1'b0, 2'b00, 1'b1, 32'hFFF, 32'd0, 2);
    push_rsp(32'd0, 1'b1);
    run_req("rng_b_1000", 1'b0, 2'b00, 1'b0, 32'h1000, 32'd0, 1);
    push_rsp(32'd0, 1'b1);
    run_req("len_illegal", 1'b0, 2'b11, 1'b0, 32'h0, 32'd0, 1);
    push_rsp(32'd0, 1'b1);
    run_req("wrap_half", 1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'd0, 1);

    // Misaligned accesses
    poke(12'h301, 8'hAA); poke(12'h302, 8'h55);
`ifdef MEM_BYTE_SEQ_MISALIGN_EN
    push_rsp(32'h000055AA, 1'b0);
    run_req("mis_half_ld", 1'b0, 2'b01, 1'b0, 32'h301, 32'd0, 3);
    push_rsp(32'h0000DEAD, 1'b0);
    run_req("mis_word_ld", 1'b0, 2'b10, 1'b0, 32'h102, 32'd0, 5);
    push_wr(32'h305, 8'h34); push_wr(32'h306, 8'h12);
    push_rsp(32'd0, 1'b0);
    run_req("mis_half_st", 1'b1, 2'b01, 1'b0, 32'h305, 32'h00001234, 3);
    chk("mis_ram_306", 32'(ram[12'h306]), 32'h12);
`else
    push_rsp(32'd0, 1'b1);
    run_req("mis_half_ld", 1'b0, 2'b01, 1'b0, 32'h301, 32'd0, 1);
    push_rsp(32'd0, 1'b1);
    run_req("mis_word_ld", 1'b0, 2'b10, 1'b0, 32'h102, 32'd0, 1);
    push_rsp(32'd0, 1'b1);
    run_req("mis_half_st", 1'b1, 2'b01, 1'b0, 32'h305, 32'h00001234, 1);
    chk("mis_ram_306", 32'(ram[12'h306]), 32'h00);
`endif

    // RAM exception mid-transfer: earlier bytes written, faulting byte and later ones not
    poke(12'h402, 8'h77);
    exc_en = 1'b1; exc_addr = 32'h402;
    push_wr(32'h400, 8'h21); push_wr(32'h401, 8'h43);
    push_rsp(32'd0, 1'b1);
    run_req("exc_st", 1'b1, 2'b10, 1'b0, 32'h400, 32'h87654321, 4);
    @(negedge clk);
    chk("exc_ram_402", 32'(ram[12'h402]), 32'h77);
    chk("exc_ram_403", 32'(ram[12'h403]), 32'h00);
    exc_addr = 32'h201;
    push_rsp(32'd0, 1'b1);
    run_req("exc_ld", 1'b0, 2'b10, 1'b0, 32'h200, 32'd0, 3);
    exc_en = 1'b0;

    // Backpressure: response held 6 cycles, competing request not accepted
    poke(12'h500, 8'h7F);
    push_rsp(32'h0000007F, 1'b0);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 32'h500, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!resp_valid && k < 20);
    chk("bp_lat", 32'(k), 32'd2);
    @(posedge clk); #1;
    push_rsp(32'h000000DE, 1'b0);
    drive(1'b0, 2'b00, 1'b0, 32'h103, 32'd0);
    repeat (6) begin
      @(negedge clk);
      chk("bp_resp_valid", 32'(resp_valid), 32'd1);
      chk("bp_resp_rdata", resp_rdata, 32'h7F);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_ready", 32'(req_ready), 32'd1);
    chk("bp_idle_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp_accepted", 32'(req_ready), 32'd0);
    k = 0;
    while (!resp_valid && k < 20) begin @(negedge clk); k++; end
    chk("bp_second_lat", 32'(k), 32'd1);

    // Reset during the second byte of a word store
    poke(12'h601, 8'h5A);
    push_wr(32'h600, 8'hD4);
    @(posedge clk); #1;
    drive(1'b1, 2'b10, 1'b0, 32'h600, 32'hA1B2C3D4);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_rw", 32'(mem_rw), 32'd0);
    @(negedge clk);
    chk("rst_mid_rw2", 32'(mem_rw), 32'd0);
    chk("rst_mid_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_ram600", 32'(ram[12'h600]), 32'hD4);
    chk("rst_mid_ram601", 32'(ram[12'h601]), 32'h5A);
    chk("rst_mid_ram602", 32'(ram[12'h602]), 32'h00);

    repeat (3) @(negedge clk);
    chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
    chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
